// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM state encoding,
// output-packing convention and two's-complement utilities.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  // Helpers work on a wide container so any operand width up to MAX_W can
  // zero-extend into them and truncate the result back.
  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0]   word_t;
  typedef logic [2*MAX_W-1:0] dword_t;

  // Result stream width: quotient and remainder side by side.
  function automatic int dout_w(input int w);
    return 2 * w;
  endfunction

  function automatic word_t neg(input word_t x);
    return ~x + word_t'(1);
  endfunction

  function automatic word_t abs_val(input word_t x, input logic sign);
    return sign ? neg(x) : x;
  endfunction

  // {q, r} with r occupying the low w bits.
  function automatic dword_t pack_dout(input word_t q, input word_t r, input int w);
    return (dword_t'(q) << w) | dword_t'(r);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring iteration on {rem, quo}.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is below 2*divisor, so a WIDTH+1-bit difference
  // never wraps and its MSB is a reliable sign.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign rem_out = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/axis_iter_divider.sv
// Iterative restoring divider with joined AXI-Stream operand inputs and a
// {quotient, remainder} result stream; RISC-V M-extension corner results.
module axis_iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_axis_dividend_tvalid,
  output logic                    s_axis_dividend_tready,
  input  logic [WIDTH-1:0]        s_axis_dividend_tdata,
  input  logic                    s_axis_divisor_tvalid,
  output logic                    s_axis_divisor_tready,
  input  logic [WIDTH-1:0]        s_axis_divisor_tdata,
  output logic                    m_axis_dout_tvalid,
  input  logic                    m_axis_dout_tready,
  output logic [dout_w(WIDTH)-1:0] m_axis_dout_tdata
);

  localparam int             DOUT_W = dout_w(WIDTH);
  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;

  logic             accept;
  logic             in_sign_a;
  logic             in_sign_b;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Join: neither operand is taken unless both are offered together.
  assign accept = (state == IDLE) & s_axis_dividend_tvalid & s_axis_divisor_tvalid & ~reset;
  assign s_axis_dividend_tready = accept;
  assign s_axis_divisor_tready  = accept;

  assign in_sign_a = SIGNED & s_axis_dividend_tdata[WIDTH-1];
  assign in_sign_b = SIGNED & s_axis_divisor_tdata[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    q_fix = quo;
    r_fix = rem;
    if (div_zero) begin
      q_fix = '1;
      r_fix = a_raw;
    end else begin
      if (sign_a ^ sign_b) q_fix = WIDTH'(neg(word_t'(quo)));
      if (sign_a)          r_fix = WIDTH'(neg(word_t'(rem)));
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      cnt                <= '0;
      a_raw              <= '0;
      dvsr               <= '0;
      rem                <= '0;
      quo                <= '0;
      sign_a             <= 1'b0;
      sign_b             <= 1'b0;
      div_zero           <= 1'b0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_raw    <= s_axis_dividend_tdata;
            dvsr     <= WIDTH'(abs_val(word_t'(s_axis_divisor_tdata), in_sign_b));
            quo      <= WIDTH'(abs_val(word_t'(s_axis_dividend_tdata), in_sign_a));
            rem      <= '0;
            sign_a   <= in_sign_a;
            sign_b   <= in_sign_b;
            div_zero <= (s_axis_divisor_tdata == '0);
            cnt      <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIXUP;
        end
        FIXUP: begin
          m_axis_dout_tdata  <= DOUT_W'(pack_dout(word_t'(q_fix), word_t'(r_fix), WIDTH));
          m_axis_dout_tvalid <= 1'b1;
          state              <= DONE;
        end
        DONE: begin
          if (m_axis_dout_tready) begin
            m_axis_dout_tvalid <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_iter_divider.sv
// Scoreboard bench for axis_iter_divider: a signed and an unsigned instance
// share operand buses; per-instance monitors pop expected results on output.
module tb_axis_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;            // 1 routes operands to the signed instance
  logic        a_valid, b_valid;
  logic [31:0] a_data, b_data;
  logic        dout_ready;

  logic        s_a_ready, s_b_ready, s_valid;
  logic [63:0] s_data;
  logic        u_a_ready, u_b_ready, u_valid;
  logic [63:0] u_data;

  logic [63:0] exp_s[$];
  logic [63:0] exp_u[$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  axis_iter_divider #(.WIDTH(32), .SIGNED(1)) u_sdiv (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tvalid (a_valid & sel),
    .s_axis_dividend_tready (s_a_ready),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_divisor_tvalid  (b_valid & sel),
    .s_axis_divisor_tready  (s_b_ready),
    .s_axis_divisor_tdata   (b_data),
    .m_axis_dout_tvalid     (s_valid),
    .m_axis_dout_tready     (dout_ready),
    .m_axis_dout_tdata      (s_data)
  );

  axis_iter_divider #(.WIDTH(32), .SIGNED(0)) u_udiv (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_dividend_tvalid (a_valid & ~sel),
    .s_axis_dividend_tready (u_a_ready),
    .s_axis_dividend_tdata  (a_data),
    .s_axis_divisor_tvalid  (b_valid & ~sel),
    .s_axis_divisor_tready  (u_b_ready),
    .s_axis_divisor_tdata   (b_data),
    .m_axis_dout_tvalid     (u_valid),
    .m_axis_dout_tready     (dout_ready),
    .m_axis_dout_tdata      (u_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: a result is consumed on the edge following a negedge where
  // tvalid and tready are both high.
  always @(negedge clk) begin
    if (!reset && s_valid && dout_ready) begin
      if (exp_s.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL s_unexpected: got %h expected none", s_data);
      end else begin
        check("s_dout", s_data, exp_s.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && u_valid && dout_ready) begin
      if (exp_u.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u_unexpected: got %h expected none", u_data);
      end else begin
        check("u_dout", u_data, exp_u.pop_front());
      end
    end
  end

  function automatic logic [1:0] readies(input bit s);
    return s ? {s_a_ready, s_b_ready} : {u_a_ready, u_b_ready};
  endfunction

  // Offer a pair and wait for the join; returns #1 after the accept edge.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input bit push);
    bit got = 1'b0;
    sel = s; a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (readies(s) == 2'b11) got = 1'b1;
    end
    if (!got) check("accept_timeout", 64'(readies(s)), 64'd3);
    else if (push) begin
      if (s) exp_s.push_back(exp);
      else   exp_u.push_back(exp);
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  // Count edges from the accept edge until tvalid rises; inputs must stay
  // refused while the instance is busy.
  task automatic wait_latency(input bit s, output int n);
    n = 0;
    do begin
      @(posedge clk); n++; #1;
      check("busy_ready_low", 64'(readies(s)), 64'd0);
    end while (!(s ? s_valid : u_valid) && n < 100);
  endtask

  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp);
    int n;
    issue(s, a, b, exp, 1'b1);
    wait_latency(s, n);
    check("latency", 64'(n), 64'd33);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [63:0] held;

    reset = 1'b1; sel = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    a_data = 32'd9; b_data = 32'd3; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", 64'(readies(1'b1)), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_data",  s_data, 64'd0);
    check("rst_u_valid", 64'(u_valid), 64'd0);
    check("rst_u_data",  u_data, 64'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Unsigned 100/7 with latency measurement and busy-refusal of a new pair.
    issue(1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b1);
    check("ready_after_accept", 64'(readies(1'b0)), 64'd0);
    a_valid = 1'b1; b_valid = 1'b1;
    wait_latency(1'b0, n);
    a_valid = 1'b0; b_valid = 1'b0;
    check("u_latency", 64'(n), 64'd33);
    @(posedge clk); #1;

    run(1'b1, 32'hFFFF_FFF9, 32'd2,          {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run(1'b1, 32'd7,         32'hFFFF_FFFE,  {32'hFFFF_FFFD, 32'h0000_0001});
    run(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  {32'h0000_000E, 32'hFFFF_FFFE});
    run(1'b1, 32'hFFFF_FFFB, 32'd0,          {32'hFFFF_FFFF, 32'hFFFF_FFFB});
    run(1'b0, 32'h1234_5678, 32'd0,          {32'hFFFF_FFFF, 32'h1234_5678});
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  {32'h8000_0000, 32'h0000_0000});
    run(1'b0, 32'hFFFF_FFFF, 32'h0000_0010,  {32'h0FFF_FFFF, 32'h0000_000F});

    // Backpressure: result held, new pair refused until the result is taken.
    dout_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd10, {32'd100, 32'd0}, 1'b1);
    wait_latency(1'b0, n);
    check("bp_latency", 64'(n), 64'd33);
    held = {32'd100, 32'd0};
    sel = 1'b0; a_data = 32'd50; b_data = 32'd5; a_valid = 1'b1; b_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(u_valid), 64'd1);
      check("bp_data",  u_data, held);
      check("bp_ready", 64'(readies(1'b0)), 64'd0);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_next_accept", 64'(readies(1'b0)), 64'd3);
    exp_u.push_back({32'd10, 32'd0});
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    wait_latency(1'b0, n);
    @(posedge clk); #1;

    // Join: a lone dividend is never consumed.
    sel = 1'b1; a_data = 32'd45; b_data = 32'd6; a_valid = 1'b1; b_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("join_wait", 64'(readies(1'b1)), 64'd0);
    end
    @(posedge clk); #1;
    b_valid = 1'b1;
    @(negedge clk);
    check("join_accept", 64'(readies(1'b1)), 64'd3);
    exp_s.push_back({32'd7, 32'd3});
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    wait_latency(1'b1, n);
    check("join_latency", 64'(n), 64'd33);
    @(posedge clk); #1;

    // Reset during CALC: aborted pair produces no result.
    issue(1'b1, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_s_valid", 64'(s_valid), 64'd0);
    check("midrst_s_data",  s_data, 64'd0);
    check("midrst_u_data",  u_data, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run(1'b1, 32'd20, 32'd3, {32'd6, 32'd2});

    repeat (40) @(posedge clk);
    #1;
    check("s_queue_empty", 64'(exp_s.size()), 64'd0);
    check("u_queue_empty", 64'(exp_u.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_iter_divider.md
Name: axis_iter_divider

Overview:
- Iterative radix-2 restoring integer divider. It is the responder end of the dividend/divisor/dout stream interface that the EX-stage divider wrapper drives.
- Accepts one operand pair by a joined AXI-Stream handshake, computes over WIDTH cycles, and returns {quotient, remainder} on a stream master port.
- Intended as the in-house replacement for the vendor divider IP: one instance with SIGNED=1, one with SIGNED=0.
- Implements RISC-V M-extension results for divide-by-zero and signed overflow.

Parameters:
- WIDTH, 32, operand width in bits; quotient and remainder each WIDTH bits.
- SIGNED, 1, 1 = two's-complement DIV/REM semantics; 0 = DIVU/REMU semantics.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend accepted.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor accepted.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- m_axis_dout_tvalid  out  1  result valid.
- m_axis_dout_tready  in  1  consumer accepts the result.
- m_axis_dout_tdata  out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.

Behaviour:
- Reset state:
  - State IDLE.
  - Counter, operand, remainder and quotient registers all 0.
  - m_axis_dout_tvalid=0, m_axis_dout_tdata=0.
  - Both tready outputs low while reset is high.
- State machine: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
- IDLE, input handshake:
  - Both tready = (state==IDLE) & dividend_tvalid & divisor_tvalid, driven combinationally and always identical. This is a join: one valid alone is never consumed.
  - On the accept edge, latch dividend/divisor.
  - SIGNED=1: also record sign_a, sign_b and divisor-zero, and store magnitudes.
  - SIGNED=0: operands are stored raw.
  - Counter <- 0; state <- CALC.
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract of divisor magnitude on a WIDTH+1-bit difference.
  - If non-negative: rem <- difference and quotient LSB <- 1; otherwise LSB <- 0.
  - After WIDTH steps (counter==WIDTH-1): state <- FIXUP.
- FIXUP, one cycle:
  - Divisor==0: quotient = all ones; remainder = original dividend (raw, not magnitude). Applies for both SIGNED values.
  - Otherwise, SIGNED=1: negate quotient if sign_a^sign_b; negate remainder if sign_a.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = most-negative, remainder = 0. The magnitude path produces this naturally; it still must be verified.
  - Load m_axis_dout_tdata; state <- DONE.
- DONE:
  - m_axis_dout_tvalid=1; tdata held stable until the edge where tready=1.
  - On that edge: tvalid <- 0, state <- IDLE.
  - tdata keeps its last value after acceptance (don't-care).
- Latency and throughput:
  - Handshake at edge n gives tvalid high after edge n+WIDTH+1 (33 edges for WIDTH=32).
  - With tready tied high: one result per WIDTH+3 cycles.
  - No overlap; inputs are not accepted outside IDLE.
- Backpressure: m_axis_dout_tready low holds DONE indefinitely with no data change.
- Input drop mid-transfer: input tvalid dropping before the join completes loses nothing, since no partial acceptance exists.
- Reset mid-operation, in any state: abort immediately, return to IDLE, tvalid=0, tdata=0. No result for the aborted pair is ever emitted.
- Unused flops: no clock enable; the block idles in IDLE with no toggling beyond the counter being held.

Decomposition:
- div_pkg holds:
  - The state typedef (IDLE, CALC, FIXUP, DONE).
  - A DOUT_W = 2*WIDTH convention.
  - A pack_dout(q, r) function returning {q, r}.
  - Helper functions abs_val and neg.
- Natural sub-module: div_step, a combinational single restoring iteration (rem_in, quo_in, divisor -> rem_out, quo_out). It is instantiated once and reused each CALC cycle.

Test Plan:
- Unsigned 100/7, dout_tready=1 -> tdata quotient=14, remainder=2; tvalid first high exactly 33 edges after the accept edge; both tready high only during the accept cycle.
- Signed -7/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Signed 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
- Divide by zero, SIGNED=1: -5/0 -> quotient=0xFFFFFFFF, remainder=0xFFFFFFFB.
- Divide by zero, SIGNED=0: 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Backpressure: result ready, dout_tready=0 for 5 cycles -> tvalid and tdata constant, both input treadys low even with new valid inputs. Then tready=1 -> accept, and the new pair is accepted one cycle later.
- Join: dividend_tvalid=1 and divisor_tvalid=0 for 4 cycles -> no tready, no accept; divisor raised -> accepted that cycle.
- Reset mid-CALC: assert reset at step 10 -> tvalid=0 and tdata=0 immediately. After release, 20/3 gives quotient=6, remainder=2 with normal latency.
